jtframe_pocket_prog: RTL and testbench
======================================

// Module: jtframe_pocket_prog
// PURPOSE
//  Downstream of the Pocket bridge/ioctl unpacker: takes the byte-wide ioctl download
//  stream, packs byte pairs into 16-bit SDRAM program words, decodes the SDRAM bank from
//  the download address and issues prog_we/prog_rdy writes to the SDRAM controller.
//  A 4-entry FIFO decouples ioctl bursts from SDRAM write latency; ioctl_busy back-pressures.
// PARAMETERS
//  BA1_START  25'h040_0000  first byte address mapped to bank 1
//  BA2_START  25'h080_0000  first byte address mapped to bank 2
//  BA3_START  25'h0C0_0000  first byte address mapped to bank 3 (requires BA1<BA2<BA3)
//  AW         22            prog_addr width (16-bit word address inside a bank)
// PORTS
//  clk           in   1   system/ROM clock
//  rst_n         in   1   asynchronous reset, active low
//  downloading   in   1   high while a data slot is being transferred
//  ioctl_addr    in   25  byte address of ioctl_dout
//  ioctl_dout    in   8   download byte
//  ioctl_wr      in   1   one-cycle strobe, byte valid
//  ioctl_busy    out  1   FIFO holds >=3 entries; upstream must not strobe
//  prog_addr     out  AW  word address, offset removed per bank
//  prog_data     out  16  {high byte, low byte}
//  prog_mask     out  2   1=byte NOT written; [1]=high, [0]=low
//  prog_ba       out  2   SDRAM bank
//  prog_we       out  1   write request, level, held until prog_rdy
//  prog_rdy      in   1   one-cycle ack from SDRAM controller
//  prog_done     out  1   one-cycle pulse: download ended and everything written
//  prog_ovf      out  1   sticky: byte dropped because FIFO was full
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, pending byte invalid, ovf clear. Async assert, sync release.
//  Bank decode (combinational on ioctl_addr): >=BA3->3, >=BA2->2, >=BA1->1, else 0;
//   offset = start of that bank; word address = (ioctl_addr-offset)>>1, truncated to AW.
//  Packer (one pending-byte register {ba,waddr,byte,valid}):
//   - wr, addr[0]=0: if pending valid, push it as {mask=2'b10}; latch new byte as pending.
//   - wr, addr[0]=1, pending valid with same ba+waddr: push {hi=dout,lo=pend}, mask=00; clear pending.
//   - wr, addr[0]=1 otherwise: push pending (if valid, mask=10) and this byte as mask=01;
//     two pushes in one cycle not allowed -> orphan pending pushed first cycle, odd byte held
//     in a 1-entry skid, pushed next cycle (ioctl_busy covers this by asserting at 3 entries).
//   - downloading 1->0 with pending valid: push it with mask=10.
//  FIFO: depth 4, entry {ba,addr,data,mask}; push when full -> entry dropped, prog_ovf<=1.
//   Push and pop in the same cycle allowed at any fill level except push-on-full.
//  Write FSM: IDLE -> (FIFO non-empty) load outputs, prog_we<=1 -> WAIT.
//   WAIT: hold addr/data/mask/ba stable; on prog_rdy: prog_we<=0 -> GAP. GAP -> IDLE (1 idle cycle
//   minimum between writes). prog_rdy outside WAIT ignored.
//  Latency: final byte of a word at cycle N -> FIFO at N+1 -> prog_we high at N+2 if idle.
//  prog_done: single pulse when downloading=0, pending invalid, skid empty, FIFO empty, FSM IDLE,
//   first time after a download. Rising downloading clears prog_ovf and re-arms prog_done.
//  downloading falling while FIFO non-empty: writes continue to drain; done waits.
//  Reset mid-write: prog_we drops immediately, queued data lost, no done pulse.
// STRUCTURE
//  Shared package jtframe_pocket_pkg: default bank starts, MASK_LO_ONLY=2'b10, MASK_HI_ONLY=2'b01,
//   MASK_WORD=2'b00, FSM state encoding.
//  Sub-module jtframe_pocket_prog_fifo: 4-deep sync FIFO, outputs full/empty/level.
//  Top holds packer, bank decode, write FSM, done/ovf logic.
// TESTING
//  Bytes 0x11@0,0x22@1, prog_rdy 3 cycles after we -> one write addr=0 data=16'h2211 mask=00 ba=0.
//  Bytes @BA2_START+4,+5 -> ba=2 prog_addr=2; @BA3_START-1 (odd) alone -> ba=2 mask=01.
//  Byte 0xAA@6 then 0xBB@10 -> writes {addr3,mask10,lo=AA} then pending @10 flushed on
//   downloading fall as {addr5,mask10,lo=BB}; then one prog_done pulse.
//  Hold prog_rdy low, stream 12 bytes ignoring ioctl_busy -> prog_ovf=1, exactly 5 writes
//   (4 FIFO + 1 in WAIT) after release; next downloading rise clears prog_ovf.
//  Assert rst_n low during WAIT -> prog_we=0 same cycle, no prog_done after release.
//  Back-to-back words with prog_rdy every cycle -> prog_we pattern 1,0(GAP),1,... no data reuse.

Source files
------------

// File: rtl/jtframe_pocket_pkg.sv
// Shared constants for the Pocket program-download path: default bank
// boundaries, byte-mask encodings, FIFO sizing and write-FSM states.
package jtframe_pocket_pkg;

  localparam logic [24:0] BA1_DEF = 25'h040_0000;
  localparam logic [24:0] BA2_DEF = 25'h080_0000;
  localparam logic [24:0] BA3_DEF = 25'h0C0_0000;

  // prog_mask bit set means that byte lane is NOT written
  localparam logic [1:0] MASK_LO_ONLY = 2'b10;
  localparam logic [1:0] MASK_HI_ONLY = 2'b01;
  localparam logic [1:0] MASK_WORD    = 2'b00;

  localparam int FIFO_DEPTH = 4;
  // busy at 3 leaves one slot for the skid push that can follow an orphan byte
  localparam int BUSY_LEVEL = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } wr_st_t;

endpackage

// File: rtl/jtframe_pocket_prog_fifo.sv
// 4-deep synchronous show-ahead FIFO. A push while full is dropped even if a
// pop happens in the same cycle; the caller flags the loss.
module jtframe_pocket_prog_fifo
  import jtframe_pocket_pkg::*;
#(
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [2:0]   level
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic [1:0]   wp, rp;
  logic         do_push, do_pop;

  assign full    = level == 3'(FIFO_DEPTH);
  assign empty   = level == 3'd0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  // storage, no reset needed: only slots below level are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // pointers and fill level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= 2'd0;
      rp    <= 2'd0;
      level <= 3'd0;
    end else begin
      if (do_push) wp <= wp + 2'd1;
      if (do_pop)  rp <= rp + 2'd1;
      level <= level + {2'b0, do_push} - {2'b0, do_pop};
    end
  end

endmodule

// File: rtl/jtframe_pocket_prog.sv
// Packs the byte-wide ioctl download into 16-bit SDRAM program writes:
// bank decode, byte pairing with a pending register and a 1-entry skid,
// a 4-entry FIFO, and a prog_we/prog_rdy write FSM with done/overflow flags.
module jtframe_pocket_prog
  import jtframe_pocket_pkg::*;
#(
  parameter logic [24:0] BA1_START = BA1_DEF,
  parameter logic [24:0] BA2_START = BA2_DEF,
  parameter logic [24:0] BA3_START = BA3_DEF,
  parameter int          AW        = 22
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          ioctl_wr,
  output logic          ioctl_busy,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic [1:0]    prog_ba,
  output logic          prog_we,
  input  logic          prog_rdy,
  output logic          prog_done,
  output logic          prog_ovf
);

  typedef struct packed {
    logic [1:0]    ba;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
  } entry_t;

  logic [1:0]    dec_ba;
  logic [24:0]   dec_off, dec_diff;
  logic [AW-1:0] dec_waddr;

  logic          pend_vld;
  logic [1:0]    pend_ba;
  logic [AW-1:0] pend_addr;
  logic [7:0]    pend_byte;
  logic          skid_vld;
  entry_t        skid_ent;

  entry_t        pend_ent, odd_ent, wr_ent, skid_new, push_ent, fifo_dout;
  logic          wr_push, wr_skid, pend_load, pend_clr, push, lost;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [2:0]    fifo_level;

  wr_st_t        st;
  logic          dl_q, dl_rise, armed, done_cond;

  // bank decode from the live ioctl address
  always_comb begin
    dec_ba  = 2'd0;
    dec_off = 25'd0;
    if (ioctl_addr >= BA3_START) begin
      dec_ba  = 2'd3;
      dec_off = BA3_START;
    end else if (ioctl_addr >= BA2_START) begin
      dec_ba  = 2'd2;
      dec_off = BA2_START;
    end else if (ioctl_addr >= BA1_START) begin
      dec_ba  = 2'd1;
      dec_off = BA1_START;
    end
  end

  assign dec_diff  = ioctl_addr - dec_off;
  assign dec_waddr = AW'(dec_diff >> 1);

  assign pend_ent = {pend_ba, pend_addr, 8'h00, pend_byte, MASK_LO_ONLY};
  assign odd_ent  = {dec_ba, dec_waddr, ioctl_dout, 8'h00, MASK_HI_ONLY};

  // packer decision; the skid always wins the single push slot
  always_comb begin
    wr_push   = 1'b0;
    wr_ent    = '0;
    wr_skid   = 1'b0;
    skid_new  = '0;
    pend_load = 1'b0;
    pend_clr  = 1'b0;
    if (ioctl_wr) begin
      if (!ioctl_addr[0]) begin
        wr_push   = pend_vld;
        wr_ent    = pend_ent;
        pend_load = 1'b1;
      end else if (pend_vld && pend_ba == dec_ba && pend_addr == dec_waddr) begin
        wr_push  = 1'b1;
        wr_ent   = {dec_ba, dec_waddr, ioctl_dout, pend_byte, MASK_WORD};
        pend_clr = 1'b1;
      end else begin
        wr_push  = 1'b1;
        pend_clr = 1'b1;
        if (pend_vld) begin
          wr_ent   = pend_ent;
          wr_skid  = 1'b1;
          skid_new = odd_ent;
        end else begin
          wr_ent = odd_ent;
        end
      end
    end else if (!downloading && pend_vld && !skid_vld) begin
      // an even byte left over when the download ends goes out alone
      wr_push  = 1'b1;
      wr_ent   = pend_ent;
      pend_clr = 1'b1;
    end
    push     = skid_vld | wr_push;
    push_ent = skid_vld ? skid_ent : wr_ent;
    // only when upstream ignores ioctl_busy right after an orphan
    lost     = skid_vld & wr_push;
  end

  // pending-byte and skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_ba   <= 2'd0;
      pend_addr <= '0;
      pend_byte <= 8'h00;
      skid_vld  <= 1'b0;
      skid_ent  <= '0;
    end else begin
      if (pend_load) begin
        pend_vld  <= 1'b1;
        pend_ba   <= dec_ba;
        pend_addr <= dec_waddr;
        pend_byte <= ioctl_dout;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
      end
      skid_vld <= wr_skid;
      if (wr_skid) skid_ent <= skid_new;
    end
  end

  assign fifo_pop   = (st == ST_IDLE) && !fifo_empty;
  assign ioctl_busy = fifo_level >= 3'(BUSY_LEVEL);

  jtframe_pocket_prog_fifo #(.W($bits(entry_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_ent),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // write FSM: outputs frozen while waiting for the ack, one idle cycle after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= 16'h0000;
      prog_mask <= 2'b00;
      prog_ba   <= 2'd0;
    end else begin
      case (st)
        ST_IDLE: if (!fifo_empty) begin
          prog_ba   <= fifo_dout.ba;
          prog_addr <= fifo_dout.addr;
          prog_data <= fifo_dout.data;
          prog_mask <= fifo_dout.mask;
          prog_we   <= 1'b1;
          st        <= ST_WAIT;
        end
        ST_WAIT: if (prog_rdy) begin
          prog_we <= 1'b0;
          st      <= ST_GAP;
        end
        ST_GAP:  st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign dl_rise   = downloading && !dl_q;
  assign done_cond = armed && !downloading && !ioctl_wr && !pend_vld && !skid_vld
                     && fifo_empty && st == ST_IDLE;

  // overflow flag and one-shot done, both re-armed by a new download
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q      <= 1'b0;
      armed     <= 1'b0;
      prog_done <= 1'b0;
      prog_ovf  <= 1'b0;
    end else begin
      dl_q      <= downloading;
      prog_done <= 1'b0;
      if (dl_rise)                         prog_ovf <= 1'b0;
      else if ((push && fifo_full) || lost) prog_ovf <= 1'b1;
      if (dl_rise) armed <= 1'b1;
      else if (done_cond) begin
        armed     <= 1'b0;
        prog_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_pocket_prog.sv
// Directed bench for jtframe_pocket_prog: a vector table of single-write
// downloads plus hand sequences for flush/done, skid, overflow, reset and
// back-to-back writes.
module tb_jtframe_pocket_prog;

  logic        clk = 1'b0;
  logic        rst_n, downloading, ioctl_wr, ioctl_busy;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask, prog_ba;
  logic        prog_we, prog_rdy, prog_done, prog_ovf;

  always #5 clk = ~clk;

  jtframe_pocket_prog dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .ioctl_busy(ioctl_busy), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_ba(prog_ba), .prog_we(prog_we),
    .prog_rdy(prog_rdy), .prog_done(prog_done), .prog_ovf(prog_ovf)
  );

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } wr_t;

  typedef struct {
    logic [24:0] a0; logic [7:0] d0;
    logic        two;
    logic [24:0] a1; logic [7:0] d1;
    logic [1:0]  ba; logic [21:0] addr; logic [15:0] data; logic [1:0] mask;
    int          lat;
  } vec_t;

  wr_t wq[$];
  wr_t prev_bus;
  logic prev_we = 1'b0;
  int checks = 0, errors = 0;
  int done_cnt = 0, done_wcnt = 0, we_rise = 0, stab_err = 0;
  int rdy_lat = 1, wcnt = 0;
  logic rdy_hold = 1'b0;
  vec_t vt[6];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    for (int i = 0; i < budget && wq.size() < n; i++) tick();
    checks++;
    if (wq.size() < n) begin
      errors++;
      $display("FAIL %s timeout got=%0d writes expected=%0d", name, wq.size(), n);
    end
  endtask

  task automatic chk_wr(input string name, input int k, input wr_t e);
    if (wq.size() > k) begin
      chk({name, "_ba"},   {30'd0, wq[k].ba},   {30'd0, e.ba});
      chk({name, "_addr"}, {10'd0, wq[k].addr}, {10'd0, e.addr});
      chk({name, "_data"}, {16'd0, wq[k].data}, {16'd0, e.data});
      chk({name, "_mask"}, {30'd0, wq[k].mask}, {30'd0, e.mask});
    end
  endtask

  // SDRAM controller model: ack rdy_lat cycles into a write unless held off
  initial begin
    prog_rdy = 1'b0;
    forever begin
      tick();
      if (prog_we) begin
        wcnt++;
        prog_rdy = (wcnt >= rdy_lat) && !rdy_hold;
      end else begin
        wcnt = 0;
        prog_rdy = 1'b0;
      end
    end
  end

  // write capture, we-edge count, bus stability during WAIT, done pulses
  always @(negedge clk) begin
    if (prog_we && prog_rdy) wq.push_back({prog_ba, prog_addr, prog_data, prog_mask});
    if (prog_we && !prev_we) we_rise++;
    if (prog_we && prev_we && {prog_ba, prog_addr, prog_data, prog_mask} != prev_bus) begin
      stab_err++;
      $display("FAIL bus_stable got=%0h expected=%0h", {prog_ba, prog_addr, prog_data, prog_mask}, prev_bus);
    end
    if (prog_done) begin
      done_cnt++;
      done_wcnt = wq.size();
    end
    prev_we  = prog_we;
    prev_bus = {prog_ba, prog_addr, prog_data, prog_mask};
  end

  initial begin
    int d0, r0;
    vt[0] = '{25'h000_0000, 8'h11, 1'b1, 25'h000_0001, 8'h22, 2'd0, 22'h000000, 16'h2211, 2'b00, 3};
    vt[1] = '{25'h080_0004, 8'h33, 1'b1, 25'h080_0005, 8'h44, 2'd2, 22'h000002, 16'h4433, 2'b00, 2};
    vt[2] = '{25'h0BF_FFFF, 8'h55, 1'b0, 25'h000_0000, 8'h00, 2'd2, 22'h1FFFFF, 16'h5500, 2'b01, 1};
    vt[3] = '{25'h040_0000, 8'h66, 1'b1, 25'h040_0001, 8'h77, 2'd1, 22'h000000, 16'h7766, 2'b00, 4};
    vt[4] = '{25'h0C0_0010, 8'h88, 1'b1, 25'h0C0_0011, 8'h99, 2'd3, 22'h000008, 16'h9988, 2'b00, 1};
    vt[5] = '{25'h03F_FFFF, 8'hAB, 1'b0, 25'h000_0000, 8'h00, 2'd0, 22'h1FFFFF, 16'hAB00, 2'b01, 2};

    rst_n = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) tick();
    chk("rst_we", {31'd0, prog_we}, 0);
    chk("rst_done", {31'd0, prog_done}, 0);
    chk("rst_ovf", {31'd0, prog_ovf}, 0);
    chk("rst_busy", {31'd0, ioctl_busy}, 0);
    chk("rst_bus", {8'd0, prog_ba, prog_addr}, 0);
    chk("rst_data", {14'd0, prog_data, prog_mask}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    downloading = 1'b1;
    tick();

    // single-write vectors, with the N+2 write latency checked on each
    for (int i = 0; i < 6; i++) begin
      wq.delete();
      rdy_lat = vt[i].lat;
      wr_byte(vt[i].a0, vt[i].d0);
      if (vt[i].two) wr_byte(vt[i].a1, vt[i].d1);
      chk($sformatf("v%0d_lat1", i), {31'd0, prog_we}, 0);
      tick();
      chk($sformatf("v%0d_lat2", i), {31'd0, prog_we}, 1);
      wait_writes($sformatf("v%0d_wait", i), 1, 40);
      chk_wr($sformatf("v%0d", i), 0, {vt[i].ba, vt[i].addr, vt[i].data, vt[i].mask});
      repeat (4) tick();
      chk($sformatf("v%0d_count", i), wq.size(), 1);
    end

    // orphan even bytes: one pushed by the next even byte, one by the download end
    wq.delete(); rdy_lat = 2;
    d0 = done_cnt;
    wr_byte(25'd6, 8'hAA);
    wr_byte(25'd10, 8'hBB);
    downloading = 1'b0;
    wait_writes("flush_wait", 2, 40);
    chk_wr("flush0", 0, {2'd0, 22'd3, 16'h00AA, 2'b10});
    chk_wr("flush1", 1, {2'd0, 22'd5, 16'h00BB, 2'b10});
    repeat (20) tick();
    chk("done_pulses", done_cnt - d0, 1);
    chk("done_after_writes", done_wcnt, 2);

    // mismatched odd byte goes through the skid
    downloading = 1'b1;
    tick();
    wq.delete();
    wr_byte(25'h20, 8'hC1);
    wr_byte(25'h23, 8'hC2);
    wait_writes("skid_wait", 2, 40);
    chk_wr("skid0", 0, {2'd0, 22'h10, 16'h00C1, 2'b10});
    chk_wr("skid1", 1, {2'd0, 22'h11, 16'hC200, 2'b01});
    repeat (4) tick();

    // overflow: stall the controller and ignore ioctl_busy
    wq.delete(); rdy_lat = 1; rdy_hold = 1'b1;
    for (int i = 0; i < 12; i++) wr_byte(25'h100 + 25'(i), 8'h10 + 8'(i));
    repeat (3) tick();
    chk("ovf_set", {31'd0, prog_ovf}, 1);
    chk("ovf_busy", {31'd0, ioctl_busy}, 1);
    rdy_hold = 1'b0;
    wait_writes("ovf_wait", 5, 100);
    repeat (20) tick();
    chk("ovf_count", wq.size(), 5);
    chk_wr("ovf_first", 0, {2'd0, 22'h80, 16'h1110, 2'b00});
    chk_wr("ovf_last", 4, {2'd0, 22'h84, 16'h1918, 2'b00});
    downloading = 1'b0;
    repeat (10) tick();
    chk("ovf_sticky", {31'd0, prog_ovf}, 1);
    downloading = 1'b1;
    repeat (2) tick();
    chk("ovf_clear", {31'd0, prog_ovf}, 0);

    // reset during WAIT
    wq.delete(); rdy_hold = 1'b1;
    wr_byte(25'h200, 8'h01);
    wr_byte(25'h201, 8'h02);
    tick();
    chk("rstw_we_hi", {31'd0, prog_we}, 1);
    rst_n = 1'b0; downloading = 1'b0;
    #1;
    chk("rstw_we_lo", {31'd0, prog_we}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    rdy_hold = 1'b0;
    d0 = done_cnt;
    repeat (20) tick();
    chk("rstw_no_done", done_cnt - d0, 0);
    chk("rstw_no_write", wq.size(), 0);

    // back-to-back words with immediate acks
    downloading = 1'b1; rdy_lat = 1;
    tick();
    wq.delete(); r0 = we_rise;
    for (int i = 0; i < 6; i++) wr_byte(25'h300 + 25'(i), 8'h31 + 8'(i));
    wait_writes("b2b_wait", 3, 60);
    repeat (5) tick();
    chk("b2b_count", wq.size(), 3);
    chk("b2b_we_edges", we_rise - r0, 3);
    chk_wr("b2b0", 0, {2'd0, 22'h180, 16'h3231, 2'b00});
    chk_wr("b2b1", 1, {2'd0, 22'h181, 16'h3433, 2'b00});
    chk_wr("b2b2", 2, {2'd0, 22'h182, 16'h3635, 2'b00});

    chk("bus_stable_total", stab_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
